// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multi-digit seven-segment scan controller with hex/decimal display
module seg7_scan_ctrl #(
  parameter int DIGITS     = 8,
  parameter int DATA_W     = 32,
  parameter int DIV        = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  input  logic              mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp,
  output logic              busy,
  output logic [6:0]        out7,
  output logic [DIGITS-1:0] en_out,
  output logic              dp_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int PAD_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               ovf_q, ovf_d;
  logic               mode_q, mode_d;
  logic               blank_q, blank_d;
  logic [DIGITS-1:0]  dp_q, dp_d;
  logic [DATA_W-1:0]  shr_q, shr_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               covf_q, covf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]   digit_q, digit_d;
  logic [6:0]         out7_q, out7_d;
  logic [DIGITS-1:0]  en_q, en_d;
  logic               dpo_q, dpo_d;

  logic [PAD_W-1:0]   value_ext;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;

  // Zero-extend (or truncate) the loaded value to the nibble width of the display.
  assign value_ext = PAD_W'(value);

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    case (n)
      4'h0: hex2seg = 7'h3F;
      4'h1: hex2seg = 7'h06;
      4'h2: hex2seg = 7'h5B;
      4'h3: hex2seg = 7'h4F;
      4'h4: hex2seg = 7'h66;
      4'h5: hex2seg = 7'h6D;
      4'h6: hex2seg = 7'h7D;
      4'h7: hex2seg = 7'h07;
      4'h8: hex2seg = 7'h7F;
      4'h9: hex2seg = 7'h6F;
      4'hA: hex2seg = 7'h77;
      4'hB: hex2seg = 7'h7C;
      4'hC: hex2seg = 7'h39;
      4'hD: hex2seg = 7'h5E;
      4'hE: hex2seg = 7'h79;
      default: hex2seg = 7'h71;
    endcase
  endfunction

  // All state registers, including the registered pin drivers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
      blank_q <= 1'b0;
      dp_q    <= '0;
      shr_q   <= '0;
      bcd_q   <= '0;
      covf_q  <= 1'b0;
      cnt_q   <= '0;
      presc_q <= '0;
      digit_q <= '0;
      out7_q  <= {7{POL}};
      en_q    <= {DIGITS{POL}};
      dpo_q   <= POL;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      shr_q   <= shr_d;
      bcd_q   <= bcd_d;
      covf_q  <= covf_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      digit_q <= digit_d;
      out7_q  <= out7_d;
      en_q    <= en_d;
      dpo_q   <= dpo_d;
    end
  end

  // Load handshake and one double-dabble step per cycle while converting.
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    dp_d    = dp_q;
    shr_d   = shr_q;
    bcd_d   = bcd_q;
    covf_d  = covf_q;
    cnt_d   = cnt_q;

    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[BCD_W-2:0], shr_q[DATA_W-1]};

    case (state_q)
      IDLE: begin
        if (load) begin
          mode_d  = mode;
          blank_d = blank_lz;
          dp_d    = dp;
          if (mode) begin
            state_d = CONV;
            shr_d   = value;
            bcd_d   = '0;
            covf_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            disp_d = value_ext[BCD_W-1:0];
            ovf_d  = 1'b0;
          end
        end
      end
      CONV: begin
        shr_d  = shr_q << 1;
        bcd_d  = bcd_shift;
        covf_d = covf_q | bcd_adj[BCD_W-1];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = IDLE;
          disp_d  = bcd_shift;
          ovf_d   = covf_q | bcd_adj[BCD_W-1];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CONV);
  end

  // Free-running prescaler; the digit index steps on every prescaler wrap.
  always_comb begin
    presc_d = presc_q + PRE_W'(1);
    digit_d = digit_q;
    if (presc_q == PRE_W'(DIV - 1)) begin
      presc_d = '0;
      digit_d = (digit_q == IDX_W'(DIGITS - 1)) ? '0 : digit_q + IDX_W'(1);
    end
  end

  // Decode the current digit, apply blanking and overflow dashes, then output polarity.
  always_comb begin
    logic              acc;
    logic [DIGITS-1:0] zero_from;
    logic [3:0]        nib;
    logic              cur_zero;
    logic              cur_dp;
    logic              blanked;
    logic [6:0]        seg_raw;
    logic [DIGITS-1:0] en_raw;
    logic              dp_raw;

    acc       = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc & (disp_q[4*i +: 4] == 4'd0);
      zero_from[i] = acc;
    end

    nib      = 4'd0;
    cur_zero = 1'b0;
    cur_dp   = 1'b0;
    en_raw   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_q == IDX_W'(i)) begin
        nib       = disp_q[4*i +: 4];
        cur_zero  = zero_from[i];
        cur_dp    = dp_q[i];
        en_raw[i] = 1'b1;
      end
    end

    blanked = blank_q && !ovf_q && (digit_q != '0) && cur_zero;
    seg_raw = ovf_q ? 7'h40 : hex2seg(nib);
    dp_raw  = cur_dp;
    if (blanked) begin
      seg_raw = 7'h00;
      en_raw  = '0;
      dp_raw  = 1'b0;
    end

    out7_d = seg_raw ^ {7{POL}};
    en_d   = en_raw ^ {DIGITS{POL}};
    dpo_d  = dp_raw ^ POL;
  end

  assign busy   = busy_q;
  assign out7   = out7_q;
  assign en_out = en_q;
  assign dp_out = dpo_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  localparam int DIGITS = 8;
  localparam int DATA_W = 32;
  localparam int DIV    = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              load = 1'b0;
  logic [DATA_W-1:0] value = '0;
  logic              mode = 1'b0;
  logic              blank_lz = 1'b0;
  logic [DIGITS-1:0] dp = '0;
  logic              busy;
  logic [6:0]        out7;
  logic [DIGITS-1:0] en_out;
  logic              dp_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0]      value;
    logic             mode;
    logic             blank;
    logic [7:0]       dp;
    logic [7:0][6:0]  seg;
    logic [7:0]       en;
    logic [7:0]       dpo;
  } vec_t;

  vec_t vecs[8];

  seg7_scan_ctrl #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .DIV(DIV), .ACTIVE_LOW(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .load(load), .value(value), .mode(mode),
    .blank_lz(blank_lz), .dp(dp), .busy(busy), .out7(out7),
    .en_out(en_out), .dp_out(dp_out)
  );

  always #5 Clk = ~Clk;

  // Edges since reset release; edge c (c>=1) drives digit ((c-1)/DIV)%DIGITS.
  always @(posedge Clk) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scan_check(input vec_t v, input string tag);
    int d;
    logic [15:0] exp;
    for (int k = 0; k < DIGITS * DIV; k++) begin
      @(negedge Clk);
      if (((cyc - 1) % DIV) == 1) begin
        d = ((cyc - 1) / DIV) % DIGITS;
        exp = {2'b00, v.seg[d], (v.en[d] ? (8'h01 << d) : 8'h00), v.dpo[d]};
        check($sformatf("%s digit%0d {seg,en,dp}", tag, d),
              {16'h0, 2'b00, out7, en_out, dp_out}, {16'h0, exp});
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 100) begin
      @(negedge Clk);
      t++;
    end
    if (busy) check({tag, " busy timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(negedge Clk);
    value = v.value; mode = v.mode; blank_lz = v.blank; dp = v.dp; load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    wait_idle(tag);
    repeat (2) @(negedge Clk);
    scan_check(v, tag);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; load = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Decimal load at negedge 0, then two one-cycle hex loads at negedges ka and kb.
  task automatic two_loads(input logic [31:0] first, input int ka, input logic [31:0] va,
                           input logic ba, input int kb, input logic [31:0] vb,
                           input logic bb, output int rises, output int falls);
    logic prev;
    @(negedge Clk);
    value = first; mode = 1'b1; blank_lz = 1'b1; dp = '0; load = 1'b1;
    prev = busy; rises = 0; falls = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge Clk);
      if (prev && !busy) falls++;
      if (!prev && busy) rises++;
      prev = busy;
      load = 1'b0;
      if (k == ka) begin load = 1'b1; value = va; mode = 1'b0; blank_lz = ba; end
      if (k == kb) begin load = 1'b1; value = vb; mode = 1'b0; blank_lz = bb; end
    end
    load = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  initial begin
    vec_t v99, vc;
    int errs, hi, rises, falls;
    logic [7:0] exp_en;

    vecs[0] = '{32'h1234ABCD, 1'b0, 1'b0, 8'h00,
                {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h77, 7'h7C, 7'h39, 7'h5E}, 8'hFF, 8'h00};
    vecs[1] = '{32'd12345678, 1'b1, 1'b0, 8'h00,
                {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F}, 8'hFF, 8'h00};
    vecs[2] = '{32'd100000000, 1'b1, 1'b1, 8'h00,
                {8{7'h40}}, 8'hFF, 8'h00};
    vecs[3] = '{32'h000000A0, 1'b0, 1'b1, 8'h02,
                {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h77, 7'h3F}, 8'h03, 8'h02};
    vecs[4] = '{32'd0, 1'b1, 1'b1, 8'hFF,
                {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 8'h01, 8'h01};
    vecs[5] = '{32'd99999999, 1'b1, 1'b0, 8'h00,
                {8{7'h6F}}, 8'hFF, 8'h00};
    vecs[6] = '{32'h00000000, 1'b0, 1'b0, 8'h80,
                {8{7'h3F}}, 8'hFF, 8'h80};
    vecs[7] = '{32'h00F00000, 1'b0, 1'b1, 8'h41,
                {7'h00, 7'h00, 7'h71, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 8'h3F, 8'h01};
    v99 = '{32'd0, 1'b1, 1'b1, 8'h00,
            {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h6F, 7'h6F}, 8'h03, 8'h00};
    vc  = '{32'd0, 1'b0, 1'b1, 8'h00,
            {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h39}, 8'h01, 8'h00};

    // Reset values while Reset is held.
    repeat (3) @(negedge Clk);
    check("reset {busy,out7,en,dp}", {15'h0, busy, out7, en_out, dp_out}, 32'h0);
    Reset = 1'b0;

    // Digit enable sequence after reset: DIV cycles per digit, wrapping after digit 7.
    errs = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge Clk);
      exp_en = 8'h01 << (((k - 1) / DIV) % DIGITS);
      if (en_out !== exp_en) errs++;
      if (k == 1) check("first digit after reset out7", 32'(out7), 32'h3F);
    end
    check("en_out scan sequence errors", 32'(errs), 32'd0);

    // Table of display vectors.
    for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Busy stays high for exactly DATA_W cycles.
    @(negedge Clk);
    value = 32'd12345678; mode = 1'b1; load = 1'b1;
    hi = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      load = 1'b0;
      if (busy) hi++;
    end
    check("busy high cycles", 32'(hi), 32'd32);

    // Loads during conversion (cycle +5 and the cycle busy falls) are ignored.
    two_loads(32'd99, 5, 32'h5, 1'b0, 32, 32'hB, 1'b0, rises, falls);
    check("load-while-busy busy rises", 32'(rises), 32'd1);
    check("load-while-busy busy falls", 32'(falls), 32'd1);
    scan_check(v99, "dec99");

    // A load on the cycle after busy falls is accepted.
    two_loads(32'd7, 32, 32'hB, 1'b0, 33, 32'hC, 1'b1, rises, falls);
    check("post-busy load busy falls", 32'(falls), 32'd1);
    scan_check(vc, "post-busy hexC");

    // Reset in the middle of a conversion.
    do_reset();
    @(negedge Clk);
    value = 32'd12345678; mode = 1'b1; blank_lz = 1'b0; dp = '0; load = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clk);
      load = 1'b0;
    end
    check("busy before mid-conv reset", 32'(busy), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mid-conv reset {busy,out7,en,dp}", {15'h0, busy, out7, en_out, dp_out}, 32'h0);
    @(negedge Clk);
    check("after reset {busy,out7,en,dp}", {15'h0, busy, out7, en_out, dp_out},
          {15'h0, 1'b0, 7'h3F, 8'h01, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
